// File: rtl/seg7_pkg.sv
// Shared types and constants for the seg7 scan controller slice.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [1:0] MODE_HEX   = 2'd0;
  localparam logic [1:0] MODE_HI    = 2'd1;
  localparam logic [1:0] MODE_LO    = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  typedef enum logic {IDLE, SCAN} state_t;

  // Control bundle presented to the shared SEG7 decoder
  typedef struct packed {
    logic [3:0] din;
    logic       num;
    logic       none;
    logic       dot;
    logic       hi_1;
    logic       hi_2;
    logic       lo_1;
    logic       lo_2;
  } seg_ctrl_t;

  localparam seg_ctrl_t SEG_OFF = '{din: 4'd0, num: 1'b0, none: 1'b1, dot: 1'b0,
                                    hi_1: 1'b0, hi_2: 1'b0, lo_1: 1'b0, lo_2: 1'b0};

endpackage

// File: rtl/seg7_scan_timer.sv
// Dwell counter and digit index for the display scan; digit_wrap/frame_wrap
// are registered flags that are high during the last dwell cycle.
module seg7_scan_timer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic                          digit_wrap,
  output logic                          frame_wrap
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_d;

  // Counter and index hold at zero while disabled so a scan starts on digit 0
  always_comb begin
    cnt_d = '0;
    idx_d = '0;
    if (en) begin
      if (digit_wrap) begin
        cnt_d = '0;
        idx_d = (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx        <= '0;
      digit_wrap <= 1'b0;
      frame_wrap <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx        <= idx_d;
      digit_wrap <= (cnt_d == CNT_MAX);
      frame_wrap <= (cnt_d == CNT_MAX) && (idx_d == IDX_LAST);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-synchronous word commit.
// Optional SEG7_LZB_EN: leading-zero blanking in HEX mode.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_mode,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_dots,
  output logic [3:0]              seg_din,
  output logic                    seg_num,
  output logic                    seg_none,
  output logic                    seg_dot,
  output logic                    seg_hi_1,
  output logic                    seg_hi_2,
  output logic                    seg_lo_1,
  output logic                    seg_lo_2,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_NEXT = IDX_W'(NUM_DIGITS - 2);

  state_t                  state_q, state_d;
  logic                    ready_d, commit, transfer;
  logic [1:0]              pend_mode, act_mode;
  logic [4*NUM_DIGITS-1:0] pend_value, act_value;
  logic [NUM_DIGITS-1:0]   pend_dots, act_dots;
  seg_ctrl_t               seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_pre, an_pre_d, shown;
  logic [IDX_W-1:0]        idx;
  logic                    digit_wrap, frame_wrap;
  logic [3:0]              nib;
  logic                    cur_dot, cur_show, nz_acc;

  seg7_scan_timer #(.NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (state_q == SCAN),
    .idx        (idx),
    .digit_wrap (digit_wrap),
    .frame_wrap (frame_wrap)
  );

  // Digits that survive blanking: at or below the highest nonzero nibble, plus digit 0
  always_comb begin
    nz_acc = 1'b0;
    shown  = '1;
`ifdef SEG7_LZB_EN
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_acc   = nz_acc | (act_value[4*i +: 4] != 4'd0);
      shown[i] = nz_acc | (i == 0);
    end
`endif
  end

  assign transfer = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    ready_d  = in_ready;
    seg_d    = SEG_OFF;
    an_pre_d = '1;
    nib      = 4'd0;
    cur_dot  = 1'b0;
    cur_show = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        nib      = act_value[4*i +: 4];
        cur_dot  = act_dots[i];
        cur_show = shown[i];
      end
    end
    case (state_q)
      IDLE: begin
        if (!in_ready) begin
          commit  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        // Pending word swaps in only as the last digit of a frame retires
        if (frame_wrap && !in_ready) commit = 1'b1;
        an_pre_d  = ~(NUM_DIGITS'(1) << idx);
        seg_d.dot = cur_dot;
        case (act_mode)
          MODE_HEX: begin
            if (cur_show) begin
              seg_d.none = 1'b0;
              seg_d.num  = 1'b1;
              seg_d.din  = nib;
            end
          end
          MODE_HI: begin
            if (idx == IDX_LAST) begin
              seg_d.none = 1'b0;
              seg_d.hi_1 = 1'b1;
            end else if (idx == IDX_NEXT) begin
              seg_d.none = 1'b0;
              seg_d.hi_2 = 1'b1;
            end
          end
          MODE_LO: begin
            if (idx == IDX_LAST) begin
              seg_d.none = 1'b0;
              seg_d.lo_1 = 1'b1;
            end else if (idx == IDX_NEXT) begin
              seg_d.none = 1'b0;
              seg_d.lo_2 = 1'b1;
            end
          end
          default: seg_d.dot = 1'b0;
        endcase
      end
      default: state_d = IDLE;
    endcase
    if (transfer)    ready_d = 1'b0;
    else if (commit) ready_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready   <= 1'b1;
      pend_mode  <= MODE_HEX;
      pend_value <= '0;
      pend_dots  <= '0;
      act_mode   <= MODE_HEX;
      act_value  <= '0;
      act_dots   <= '0;
      seg_q      <= SEG_OFF;
      an_pre     <= '1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= ready_d;
      if (transfer) begin
        pend_mode  <= in_mode;
        pend_value <= in_value;
        pend_dots  <= in_dots;
      end
      if (commit) begin
        act_mode  <= pend_mode;
        act_value <= pend_value;
        act_dots  <= pend_dots;
      end
      seg_q      <= seg_d;
      an_pre     <= an_pre_d;
      an         <= an_pre;
      frame_done <= frame_wrap;
    end
  end

  assign seg_din  = seg_q.din;
  assign seg_num  = seg_q.num;
  assign seg_none = seg_q.none;
  assign seg_dot  = seg_q.dot;
  assign seg_hi_1 = seg_q.hi_1;
  assign seg_hi_2 = seg_q.hi_2;
  assign seg_lo_1 = seg_q.lo_1;
  assign seg_lo_2 = seg_q.lo_2;

endmodule
